// File: rtl/writeback_arbiter_if.sv
// -----------------------------------------------------------------------------
// writeback_arbiter_if
//   Bundles every non-clock signal of the write-back arbiter.
//   slave  : the arbiter itself (consumes results and queries, drives the
//            register-file write port, handshake ready and pending flags).
//   master : the pipeline side that offers results and asks hazard queries.
//
//   ALU path    : alu_valid, alu_rd, alu_data
//   LSU path    : lsu_valid, lsu_ready, lsu_rd, lsu_data
//   Write port  : EnableWrite, write_reg, write_data (registered)
//   Hazard query: read_reg1/2 -> pend1/2 (combinational)
//   Occupancy   : fifo_count (valid + killed entries held)
// -----------------------------------------------------------------------------
interface writeback_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;

  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;

  logic              EnableWrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;

  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic              pend1;
  logic              pend2;

  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output read_reg1, read_reg2,
    input  lsu_ready, EnableWrite, write_reg, write_data,
    input  pend1, pend2, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  read_reg1, read_reg2,
    output lsu_ready, EnableWrite, write_reg, write_data,
    output pend1, pend2, fifo_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//   Drives the single register-file write port from two result sources:
//   single-cycle ALU results (always win, never stalled) and long-latency
//   load/multiply results queued in a DEPTH-entry FIFO with valid/ready.
//   A winning ALU write to R kills every queued write to R (the queued result
//   is older in program order), and killed entries drain without writing.
//
//   clk   : clock, all state updates on posedge
//   rst_n : asynchronous active-low reset
//   bus   : writeback_arbiter_if.slave (see interface header for signals)
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  writeback_arbiter_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  // Write-port registers
  logic              r_en;
  logic [ADDR_W-1:0] r_wreg;
  logic [DATA_W-1:0] r_wdata;

  // FIFO state: per-entry valid bit plus payload
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic w_ready;
  logic w_alu_win;
  logic w_push;
  logic w_pop;
  logic w_push_killed;
  logic w_pend1;
  logic w_pend2;

  // Ready looks only at registered occupancy, never at a same-cycle pop.
  assign w_ready   = (r_count < FULL_C);
  assign w_alu_win = bus.alu_valid && (bus.alu_rd != '0);
  // An r0 result completes the handshake but occupies no slot.
  assign w_push    = bus.lsu_valid && w_ready && (bus.lsu_rd != '0);
  assign w_pop     = !w_alu_win && (r_count != '0);
  // The LSU result is older than a concurrent ALU result to the same rd.
  assign w_push_killed = w_alu_win && (bus.lsu_rd == bus.alu_rd);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Output selection
      if (w_alu_win) begin
        r_en    <= 1'b1;
        r_wreg  <= bus.alu_rd;
        r_wdata <= bus.alu_data;
      end else if (w_pop) begin
        if (r_valid[r_head]) begin
          r_en    <= 1'b1;
          r_wreg  <= r_rd[r_head];
          r_wdata <= r_data[r_head];
        end else begin
          r_en <= 1'b0;
        end
      end else begin
        r_en <= 1'b0;
      end

      // Valid bits: push sets the tail, WAW kill clears matches, pop retires
      // the head. Tail and head coincide only when empty or full, where push
      // and pop cannot both happen.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_tail == PTR_W'(i))) begin
          r_valid[i] <= !w_push_killed;
        end else if (w_alu_win && (r_rd[i] == bus.alu_rd)) begin
          r_valid[i] <= 1'b0;
        end else if (w_pop && (r_head == PTR_W'(i))) begin
          r_valid[i] <= 1'b0;
        end
      end

      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // NOTE: the payload array has no reset; it is only observed through a set
  // valid bit, so clearing it would cost reset fan-out for no behaviour.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_tail]   <= bus.lsu_rd;
      r_data[r_tail] <= bus.lsu_data;
    end
  end

  // Pending = any live queued write or the write currently on the port.
  // NOTE: each output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_pend1 = 1'b0;
    w_pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_rd[i] == bus.read_reg1)) w_pend1 = 1'b1;
      if (r_valid[i] && (r_rd[i] == bus.read_reg2)) w_pend2 = 1'b1;
    end
    if (r_en && (r_wreg == bus.read_reg1)) w_pend1 = 1'b1;
    if (r_en && (r_wreg == bus.read_reg2)) w_pend2 = 1'b1;
    if (bus.read_reg1 == '0) w_pend1 = 1'b0;
    if (bus.read_reg2 == '0) w_pend2 = 1'b0;
  end

  assign bus.lsu_ready   = w_ready;
  assign bus.EnableWrite = r_en;
  assign bus.write_reg   = r_wreg;
  assign bus.write_data  = r_wdata;
  assign bus.pend1       = w_pend1;
  assign bus.pend2       = w_pend2;
  assign bus.fifo_count  = r_count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
//   Directed scenarios for writeback_arbiter. Inputs change 1 ns after the
//   rising edge; outputs are sampled at that same point, so each sample shows
//   the state produced by the edge just taken.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  writeback_arbiter_if #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) bus ();

  writeback_arbiter #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow register file fed by the write port, to check final contents.
  logic [31:0] rf [32];
  logic        r0_written;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      r0_written <= 1'b0;
    end else if (bus.EnableWrite) begin
      rf[bus.write_reg] <= bus.write_data;
      if (bus.write_reg == 5'd0) r0_written <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.lsu_valid = v; bus.lsu_rd = rd; bus.lsu_data = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.read_reg1 = 5'd0;
    bus.read_reg2 = 5'd0;
    #3;
    checks++; if (bus.EnableWrite !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", bus.EnableWrite); end
    checks++; if (bus.write_reg !== 5'd0) begin errors++; $display("FAIL reset_wreg: got %0d want 0", bus.write_reg); end
    checks++; if (bus.write_data !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %0d want 0", bus.write_data); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
    checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.lsu_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.EnableWrite !== 1'b0) begin errors++; $display("FAIL post_reset_en: got %b want 0", bus.EnableWrite); end
  endtask

  task automatic test_alu_only();
    drive_alu(1'b1, 5'd9, 32'd66);
    tick();
    checks++; if (bus.EnableWrite !== 1'b1) begin errors++; $display("FAIL alu_en: got %b want 1", bus.EnableWrite); end
    checks++; if (bus.write_reg !== 5'd9) begin errors++; $display("FAIL alu_wreg: got %0d want 9", bus.write_reg); end
    checks++; if (bus.write_data !== 32'd66) begin errors++; $display("FAIL alu_wdata: got %0d want 66", bus.write_data); end
    idle();
    tick();
    checks++; if (bus.EnableWrite !== 1'b0) begin errors++; $display("FAIL alu_idle_en: got %b want 0", bus.EnableWrite); end
    checks++; if (bus.write_reg !== 5'd9) begin errors++; $display("FAIL alu_idle_wreg: got %0d want 9", bus.write_reg); end
    checks++; if (bus.write_data !== 32'd66) begin errors++; $display("FAIL alu_idle_wdata: got %0d want 66", bus.write_data); end
  endtask

  task automatic test_fill_drain();
    logic [4:0]  rds [4];
    logic [31:0] dat [4];
    rds = '{5'd16, 5'd19, 5'd20, 5'd21};
    dat = '{32'd232, 32'd5, 32'd15, 32'd40};
    drive_alu(1'b1, 5'd10, 32'd100);
    for (int i = 0; i < 4; i++) begin
      drive_lsu(1'b1, rds[i], dat[i]);
      tick();
      checks++; if (bus.fifo_count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.fifo_count, i + 1); end
      checks++; if (bus.write_reg !== 5'd10) begin errors++; $display("FAIL fill_alu_wreg[%0d]: got %0d want 10", i, bus.write_reg); end
    end
    checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", bus.lsu_ready); end
    // A push offered while full must be refused.
    drive_lsu(1'b1, 5'd30, 32'd999);
    tick();
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_hold_count: got %0d want 4", bus.fifo_count); end
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.EnableWrite !== 1'b1) begin errors++; $display("FAIL drain_en[%0d]: got %b want 1", i, bus.EnableWrite); end
      checks++; if (bus.write_reg !== rds[i]) begin errors++; $display("FAIL drain_wreg[%0d]: got %0d want %0d", i, bus.write_reg, rds[i]); end
      checks++; if (bus.write_data !== dat[i]) begin errors++; $display("FAIL drain_wdata[%0d]: got %0d want %0d", i, bus.write_data, dat[i]); end
      checks++; if (bus.fifo_count !== 3'(3 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, bus.fifo_count, 3 - i); end
      checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL drain_ready[%0d]: got %b want 1", i, bus.lsu_ready); end
    end
    tick();
    checks++; if (bus.EnableWrite !== 1'b0) begin errors++; $display("FAIL drained_en: got %b want 0", bus.EnableWrite); end
  endtask

  task automatic test_push_pop();
    // Continuous LSU stream with idle ALU: from the second push on, a pop
    // happens on the same edge and the count stays at 1.
    drive_lsu(1'b1, 5'd11, 32'd110);
    tick();
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL pp_count0: got %0d want 1", bus.fifo_count); end
    drive_lsu(1'b1, 5'd12, 32'd120);
    tick();
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL pp_count1: got %0d want 1", bus.fifo_count); end
    checks++; if (bus.write_reg !== 5'd11 || bus.EnableWrite !== 1'b1) begin errors++; $display("FAIL pp_write1: got en=%b reg=%0d want en=1 reg=11", bus.EnableWrite, bus.write_reg); end
    drive_lsu(1'b1, 5'd13, 32'd130);
    tick();
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL pp_count2: got %0d want 1", bus.fifo_count); end
    checks++; if (bus.write_data !== 32'd120) begin errors++; $display("FAIL pp_write2: got %0d want 120", bus.write_data); end
    idle();
    tick();
    checks++; if (bus.fifo_count !== 3'd0 || bus.write_reg !== 5'd13) begin errors++; $display("FAIL pp_last: got count=%0d reg=%0d want count=0 reg=13", bus.fifo_count, bus.write_reg); end
    tick();
  endtask

  task automatic test_waw_kill();
    bus.read_reg1 = 5'd5;
    drive_alu(1'b1, 5'd6, 32'd60);
    drive_lsu(1'b1, 5'd5, 32'd1);
    tick();
    checks++; if (bus.pend1 !== 1'b1) begin errors++; $display("FAIL waw_pend_buf: got %b want 1", bus.pend1); end
    drive_alu(1'b1, 5'd5, 32'd2);
    drive_lsu(1'b0, 5'd0, 32'd0);
    tick();
    checks++; if (bus.write_reg !== 5'd5 || bus.write_data !== 32'd2) begin errors++; $display("FAIL waw_alu_write: got reg=%0d data=%0d want reg=5 data=2", bus.write_reg, bus.write_data); end
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL waw_count: got %0d want 1", bus.fifo_count); end
    idle();
    tick();
    checks++; if (bus.EnableWrite !== 1'b0) begin errors++; $display("FAIL waw_killed_pop_en: got %b want 0", bus.EnableWrite); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL waw_drained: got %0d want 0", bus.fifo_count); end
    checks++; if (bus.pend1 !== 1'b0) begin errors++; $display("FAIL waw_pend_clear: got %b want 0", bus.pend1); end
    tick();
    checks++; if (rf[5] !== 32'd2) begin errors++; $display("FAIL waw_final_r5: got %0d want 2", rf[5]); end
    bus.read_reg1 = 5'd0;
  endtask

  task automatic test_same_cycle();
    bus.read_reg2 = 5'd7;
    drive_alu(1'b1, 5'd7, 32'd70);
    drive_lsu(1'b1, 5'd7, 32'd77);
    tick();
    checks++; if (bus.EnableWrite !== 1'b1 || bus.write_reg !== 5'd7 || bus.write_data !== 32'd70) begin errors++; $display("FAIL same_write: got en=%b reg=%0d data=%0d want en=1 reg=7 data=70", bus.EnableWrite, bus.write_reg, bus.write_data); end
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL same_count: got %0d want 1", bus.fifo_count); end
    checks++; if (bus.pend2 !== 1'b1) begin errors++; $display("FAIL same_pend_write: got %b want 1", bus.pend2); end
    idle();
    tick();
    checks++; if (bus.EnableWrite !== 1'b0) begin errors++; $display("FAIL same_killed_pop: got %b want 0", bus.EnableWrite); end
    checks++; if (bus.pend2 !== 1'b0) begin errors++; $display("FAIL same_pend_clear: got %b want 0", bus.pend2); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL same_drained: got %0d want 0", bus.fifo_count); end
    tick();
    checks++; if (rf[7] !== 32'd70) begin errors++; $display("FAIL same_final_r7: got %0d want 70", rf[7]); end
    bus.read_reg2 = 5'd0;
  endtask

  task automatic test_pending_r0();
    bus.read_reg1 = 5'd3;
    bus.read_reg2 = 5'd0;
    drive_alu(1'b1, 5'd4, 32'd40);
    drive_lsu(1'b1, 5'd3, 32'd33);
    tick();
    checks++; if (bus.pend1 !== 1'b1) begin errors++; $display("FAIL pend_buffered: got %b want 1", bus.pend1); end
    checks++; if (bus.pend2 !== 1'b0) begin errors++; $display("FAIL pend_r0: got %b want 0", bus.pend2); end
    // r0 LSU result: handshake completes, nothing stored.
    drive_alu(1'b1, 5'd4, 32'd41);
    drive_lsu(1'b1, 5'd0, 32'd55);
    #1;
    checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL r0_ready: got %b want 1", bus.lsu_ready); end
    tick();
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL r0_lsu_count: got %0d want 1", bus.fifo_count); end
    checks++; if (bus.pend1 !== 1'b1) begin errors++; $display("FAIL pend_still: got %b want 1", bus.pend1); end
    // ALU valid with rd=0 does not win: the FIFO pops.
    drive_alu(1'b1, 5'd0, 32'd99);
    drive_lsu(1'b0, 5'd0, 32'd0);
    tick();
    checks++; if (bus.EnableWrite !== 1'b1 || bus.write_reg !== 5'd3 || bus.write_data !== 32'd33) begin errors++; $display("FAIL r0_alu_pop: got en=%b reg=%0d data=%0d want en=1 reg=3 data=33", bus.EnableWrite, bus.write_reg, bus.write_data); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL r0_alu_count: got %0d want 0", bus.fifo_count); end
    checks++; if (bus.pend1 !== 1'b1) begin errors++; $display("FAIL pend_write_cycle: got %b want 1", bus.pend1); end
    idle();
    tick();
    checks++; if (bus.pend1 !== 1'b0) begin errors++; $display("FAIL pend_after_write: got %b want 0", bus.pend1); end
    checks++; if (r0_written !== 1'b0) begin errors++; $display("FAIL r0_never_written: got %b want 0", r0_written); end
    bus.read_reg1 = 5'd0;
  endtask

  task automatic test_async_reset();
    drive_alu(1'b1, 5'd1, 32'd11);
    for (int i = 0; i < 3; i++) begin
      drive_lsu(1'b1, 5'(24 + i), 32'(240 + i));
      tick();
    end
    checks++; if (bus.fifo_count !== 3'd3 || bus.EnableWrite !== 1'b1) begin errors++; $display("FAIL ar_setup: got count=%0d en=%b want count=3 en=1", bus.fifo_count, bus.EnableWrite); end
    idle();
    bus.read_reg1 = 5'd24;
    bus.read_reg2 = 5'd25;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.EnableWrite !== 1'b0) begin errors++; $display("FAIL ar_en_immediate: got %b want 0", bus.EnableWrite); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL ar_count_immediate: got %0d want 0", bus.fifo_count); end
    checks++; if (bus.write_reg !== 5'd0) begin errors++; $display("FAIL ar_wreg_immediate: got %0d want 0", bus.write_reg); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b want 1", bus.lsu_ready); end
    checks++; if (bus.pend1 !== 1'b0 || bus.pend2 !== 1'b0) begin errors++; $display("FAIL ar_pend: got %b%b want 00", bus.pend1, bus.pend2); end
    checks++; if (bus.EnableWrite !== 1'b0) begin errors++; $display("FAIL ar_no_stale_write: got %b want 0", bus.EnableWrite); end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_fill_drain();
    test_push_pop();
    test_waw_kill();
    test_same_cycle();
    test_pending_r0();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
